// File: rtl/div_ctrl_if.sv
// -----------------------------------------------------------------------------
// div_ctrl_if
// Request/response bundle between the EX stage (master) and the divide
// sequencer (slave).
//   signed_div_i  1 = DIV (two's complement), 0 = DIVU
//   opdata1_i     dividend
//   opdata2_i     divisor
//   start_i       request, held by EX until ready_o is seen
//   annul_i       abort the operation in flight (flush)
//   result_o      {remainder, quotient} for HI/LO
//   ready_o       result valid
//   stall_o       pipeline stall request
// -----------------------------------------------------------------------------
interface div_ctrl_if;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;
  logic        stall_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o, stall_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o, stall_o
  );
endinterface

// File: rtl/div_ctrl.sv
// -----------------------------------------------------------------------------
// div_ctrl
// Multi-cycle divide sequencer beside EX. A DIV/DIVU request is latched in
// IDLE, divided by 32 iterations of radix-2 restoring division (one per
// cycle), sign-corrected, and presented as {remainder, quotient}. The pipeline
// is stalled from the accepting cycle until the result is ready.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-low reset
//   bus  div_ctrl_if.slave (operands, start/annul in; result/ready/stall out)
// -----------------------------------------------------------------------------
module div_ctrl (
  input  logic       clk,
  input  logic       rst,
  div_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_BY_ZERO = 2'd1,
    S_ON      = 2'd2,
    S_END     = 2'd3
  } state_t;

  state_t      state_q;
  logic [4:0]  cnt_q;
  logic [31:0] r_q;       // partial remainder
  logic [31:0] q_q;       // dividend magnitude shifting out, quotient shifting in
  logic [31:0] dvsr_q;    // divisor magnitude
  logic        neg_a_q;   // dividend was negative (signed op only)
  logic        neg_b_q;   // divisor was negative (signed op only)
  logic [63:0] result_q;
  logic        ready_q;

  function automatic logic [31:0] negate(input logic [31:0] v);
    return ~v + 32'd1;
  endfunction

  // One restoring step. The borrow out of the 33-bit subtraction tells
  // whether the trial value was below the divisor.
  logic [32:0] trial;
  logic [32:0] diff;
  logic        fits;
  logic [31:0] r_d;
  logic [31:0] q_d;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;

  assign trial   = {r_q, q_q[31]};
  assign diff    = trial - {1'b0, dvsr_q};
  assign fits    = ~diff[32];
  assign r_d     = fits ? diff[31:0] : trial[31:0];
  assign q_d     = {q_q[30:0], fits};
  // Sign flags are only ever set for DIV, so DIVU passes straight through.
  // -2^31 / -1 naturally wraps back to 0x80000000 here.
  assign quo_fix = (neg_a_q ^ neg_b_q) ? negate(q_d) : q_d;
  assign rem_fix = neg_a_q ? negate(r_d) : r_d;

  logic op1_neg;
  logic op2_neg;
  assign op1_neg = bus.signed_div_i & bus.opdata1_i[31];
  assign op2_neg = bus.signed_div_i & bus.opdata2_i[31];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= 5'd0;
      r_q      <= 32'd0;
      q_q      <= 32'd0;
      dvsr_q   <= 32'd0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      result_q <= 64'd0;
      ready_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          ready_q  <= 1'b0;
          result_q <= 64'd0;
          if (bus.start_i && !bus.annul_i) begin
            neg_a_q <= op1_neg;
            neg_b_q <= op2_neg;
            q_q     <= op1_neg ? negate(bus.opdata1_i) : bus.opdata1_i;
            dvsr_q  <= op2_neg ? negate(bus.opdata2_i) : bus.opdata2_i;
            r_q     <= 32'd0;
            cnt_q   <= 5'd0;
            state_q <= (bus.opdata2_i == 32'd0) ? S_BY_ZERO : S_ON;
          end
        end

        S_BY_ZERO: begin
          result_q <= 64'd0;
          if (bus.annul_i) begin
            ready_q <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            ready_q <= 1'b1;
            state_q <= S_END;
          end
        end

        S_ON: begin
          if (bus.annul_i) begin
            ready_q  <= 1'b0;
            result_q <= 64'd0;
            cnt_q    <= 5'd0;
            state_q  <= S_IDLE;
          end else begin
            r_q   <= r_d;
            q_q   <= q_d;
            cnt_q <= cnt_q + 5'd1;
            if (cnt_q == 5'd31) begin
              result_q <= {rem_fix, quo_fix};
              ready_q  <= 1'b1;
              state_q  <= S_END;
            end
          end
        end

        S_END: begin
          // Holding start keeps the result up; no restart from here.
          if (!bus.start_i) begin
            ready_q  <= 1'b0;
            result_q <= 64'd0;
            state_q  <= S_IDLE;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.result_o = result_q;
  assign bus.ready_o  = ready_q;
  // Gated by rst so the stall drops immediately when reset is asserted.
  assign bus.stall_o  = rst & (
                          ((state_q == S_IDLE) && bus.start_i && !bus.annul_i) ||
                          ((state_q == S_BY_ZERO) && !bus.annul_i) ||
                          ((state_q == S_ON) && !bus.annul_i));

endmodule
